// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand selection, forwarding and hazard detection.
// Optional macro ID_EX_FWD_EN: enables EX/MEM and MEM/WB forwarding plus stall write-back capture.
module id_ex_operand_stage #(
  parameter int XLEN      = 32,
  parameter int NREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [XLEN-1:0]      id_pc,
  input  logic [XLEN-1:0]      id_imm,
  input  logic [XLEN-1:0]      id_rs1_data,
  input  logic [XLEN-1:0]      id_rs2_data,
  input  logic [NREG_BITS-1:0] id_rs1_addr,
  input  logic [NREG_BITS-1:0] id_rs2_addr,
  input  logic [NREG_BITS-1:0] id_rd_addr,
  input  logic [3:0]           id_alu_code,
  input  logic [1:0]           id_a_sel,
  input  logic [1:0]           id_b_sel,
  input  logic                 id_reg_write,
  input  logic                 id_mem_read,
  input  logic                 id_mem_write,
  input  logic [NREG_BITS-1:0] exmem_rd,
  input  logic                 exmem_reg_write,
  input  logic [XLEN-1:0]      exmem_result,
  input  logic [NREG_BITS-1:0] memwb_rd,
  input  logic                 memwb_reg_write,
  input  logic [XLEN-1:0]      memwb_result,
  output logic [3:0]           ALUopcode,
  output logic [XLEN-1:0]      ALUin_a,
  output logic [XLEN-1:0]      ALUin_b,
  output logic [XLEN-1:0]      ex_store_data,
  output logic                 ex_valid,
  output logic [NREG_BITS-1:0] ex_rd_addr,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_illegal,
  output logic                 load_use_hazard
);

  logic                 valid_q, valid_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic [XLEN-1:0]      imm_q, imm_d;
  logic [XLEN-1:0]      rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]      rs2_data_q, rs2_data_d;
  logic [NREG_BITS-1:0] rs1_addr_q, rs1_addr_d;
  logic [NREG_BITS-1:0] rs2_addr_q, rs2_addr_d;
  logic [NREG_BITS-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]           alu_code_q, alu_code_d;
  logic [1:0]           a_sel_q, a_sel_d;
  logic [1:0]           b_sel_q, b_sel_d;
  logic                 reg_write_q, reg_write_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic                 illegal_q, illegal_d;

  logic                 id_illegal;
  logic [XLEN-1:0]      rs1_val, rs2_val;

  assign id_illegal = (id_alu_code > 4'd10);

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    alu_code_d  = alu_code_q;
    a_sel_d     = a_sel_q;
    b_sel_d     = b_sel_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    illegal_d   = illegal_q;
    if (flush) begin
      // Bubble: every field is zeroed so the stage is a clean no-op add.
      valid_d     = 1'b0;
      pc_d        = '0;
      imm_d       = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      rs1_addr_d  = '0;
      rs2_addr_d  = '0;
      rd_addr_d   = '0;
      alu_code_d  = 4'd0;
      a_sel_d     = 2'd0;
      b_sel_d     = 2'd0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      illegal_d   = 1'b0;
    end else if (stall) begin
`ifdef ID_EX_FWD_EN
      // A value retiring from WB while we hold must not be lost.
      if (memwb_reg_write && (memwb_rd == rs1_addr_q) && (rs1_addr_q != '0))
        rs1_data_d = memwb_result;
      if (memwb_reg_write && (memwb_rd == rs2_addr_q) && (rs2_addr_q != '0))
        rs2_data_d = memwb_result;
`endif
    end else begin
      valid_d     = id_valid;
      pc_d        = id_pc;
      imm_d       = id_imm;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      rs1_addr_d  = id_rs1_addr;
      rs2_addr_d  = id_rs2_addr;
      rd_addr_d   = id_rd_addr;
      alu_code_d  = id_illegal ? 4'd0 : id_alu_code;
      a_sel_d     = id_a_sel;
      b_sel_d     = id_b_sel;
      reg_write_d = id_reg_write & ~id_illegal;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write & ~id_illegal;
      illegal_d   = id_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      alu_code_q  <= 4'd0;
      a_sel_q     <= 2'd0;
      b_sel_q     <= 2'd0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      alu_code_q  <= alu_code_d;
      a_sel_q     <= a_sel_d;
      b_sel_q     <= b_sel_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      illegal_q   <= illegal_d;
    end
  end

`ifdef ID_EX_FWD_EN
  function automatic logic [XLEN-1:0] fwd_value(input logic [NREG_BITS-1:0] addr,
                                                input logic [XLEN-1:0]      data);
    logic [XLEN-1:0] v;
    v = data;
    if (addr == '0)
      v = '0;
    else if (exmem_reg_write && (exmem_rd == addr))
      v = exmem_result;
    else if (memwb_reg_write && (memwb_rd == addr))
      v = memwb_result;
    return v;
  endfunction

  assign rs1_val = fwd_value(rs1_addr_q, rs1_data_q);
  assign rs2_val = fwd_value(rs2_addr_q, rs2_data_q);

  assign load_use_hazard = valid_q & mem_read_q & (rd_addr_q != '0) & id_valid &
                           ((rd_addr_q == id_rs1_addr) | (rd_addr_q == id_rs2_addr));
`else
  // Without forwarding any in-flight writer of a source register is a hazard.
  function automatic logic raw_match(input logic [NREG_BITS-1:0] addr);
    return (addr != '0) &&
           ((reg_write_q && (rd_addr_q == addr)) ||
            (exmem_reg_write && (exmem_rd == addr)) ||
            (memwb_reg_write && (memwb_rd == addr)));
  endfunction

  logic unused_fwd_data;
  assign unused_fwd_data = ^{exmem_result, memwb_result};

  assign rs1_val = rs1_data_q;
  assign rs2_val = rs2_data_q;

  assign load_use_hazard = id_valid & (raw_match(id_rs1_addr) | raw_match(id_rs2_addr));
`endif

  always_comb begin
    ALUin_a = rs1_val;
    case (a_sel_q)
      2'd1:    ALUin_a = pc_q;
      2'd2:    ALUin_a = '0;
      default: ALUin_a = rs1_val;
    endcase
  end

  always_comb begin
    ALUin_b = rs2_val;
    case (b_sel_q)
      2'd1:    ALUin_b = imm_q;
      2'd2:    ALUin_b = XLEN'(4);
      default: ALUin_b = rs2_val;
    endcase
  end

  assign ALUopcode     = alu_code_q;
  assign ex_store_data = rs2_val;
  assign ex_valid      = valid_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_illegal    = illegal_q;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-stage operand selection for the RISC-V core; sits directly upstream of the ALU and drives its ALUopcode, ALUin_a and ALUin_b.
- Latches decoded fields from ID, forwards results from the EX/MEM and MEM/WB stages, and detects load-use hazards.
- Supports stall (hold) and flush (bubble insertion).

Parameters:
- XLEN, 32, datapath width.
- NREG_BITS, 5, register address width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hold the stage contents.
- flush  in  1  insert a bubble; dominates stall.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_imm  in  XLEN  sign-extended immediate (already shifted for LUI).
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  NREG_BITS  register indices.
- id_alu_code  in  4  0 add, 1 sub, 2 lui, 3 and, 4 xor, 5 or, 6 sll, 7 srl, 8 sra, 9 slt, 10 sltu.
- id_a_sel  in  2  A operand source: 0 rs1, 1 pc, 2 zero.
- id_b_sel  in  2  B operand source: 0 rs2, 1 imm, 2 constant 4.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- exmem_rd  in  NREG_BITS;  exmem_reg_write  in  1;  exmem_result  in  XLEN.
- memwb_rd  in  NREG_BITS;  memwb_reg_write  in  1;  memwb_result  in  XLEN.
- ALUopcode  out  4  to ALU.
- ALUin_a, ALUin_b  out  XLEN  to ALU.
- ex_store_data  out  XLEN  forwarded rs2 value for stores.
- ex_valid, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write  out  pass-through controls.
- ex_illegal  out  1  latched instruction had alu_code > 10.
- load_use_hazard  out  1  combinational; ID must stall.

Behaviour:
- Reset (rst_n=0 at the clock edge): all registers clear to 0.
  - Resulting outputs: ALUopcode 0, ALUin_a 0, ALUin_b 0, ex_store_data 0, all ex_* 0.
  - Reset asserted mid-stall or mid-flush wins unconditionally.
- Register update priority per edge: reset > flush > stall > load.
  - Flush: valid, reg_write, mem_read, mem_write, illegal and alu_code all cleared; rs/rd addresses cleared to 0.
  - Stall: all fields hold, except the stall write-back capture below.
  - Load: all id_* fields captured.
- Illegal code: an id_alu_code of 11..15 is loaded as 0 (add) with ex_illegal=1. reg_write and mem_write are forced to 0 for that instruction.
- Latency: one cycle from ID inputs to the registered fields. Operand outputs are combinational from the registered fields and forwarding inputs, so the ALU result is valid in the same cycle.
- Forwarding, evaluated separately for rs1 and rs2 using the registered address:
  - Forward exmem_result if exmem_reg_write=1 and exmem_rd equals the address and is nonzero.
  - Otherwise forward memwb_result under the same conditions.
  - Otherwise use the registered register-file data.
  - EX/MEM has priority when both stages match.
  - x0 is never forwarded; its operand reads 0.
- ALUin_a = rs1 forwarded value, registered pc, or 0, selected by a_sel. An a_sel of 3 is treated as 0.
- ALUin_b = rs2 forwarded value, registered imm, or 32'd4, selected by b_sel. A b_sel of 3 is treated as 0.
- ex_store_data is always the rs2 forwarded value, regardless of b_sel.
- Stall write-back capture: while stalled, if memwb_reg_write=1 and memwb_rd matches a nonzero registered rs address, the stored data for that operand is overwritten with memwb_result. This prevents losing a value that retires during the stall.
- load_use_hazard = ex_valid & ex_mem_read & (ex_rd_addr != 0), AND-ed with: id_valid and (ex_rd_addr == id_rs1_addr or ex_rd_addr == id_rs2_addr).
  - Stage invariant: a stalled ID must be accompanied by flush=1 here, so a bubble is inserted.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding and stall capture operate as specified above.
- Undefined: no forwarding and no stall capture; operands come from the registered data only.
  - load_use_hazard widens to a full RAW hazard: asserted when id_valid and a nonzero id_rs1_addr or id_rs2_addr matches any of:
    - ex_rd_addr with ex_reg_write=1;
    - exmem_rd with exmem_reg_write=1;
    - memwb_rd with memwb_reg_write=1.

Test Plan:
- Reset: drive random id_* with rst_n=0 for 2 edges -> all outputs 0. Release reset with id_alu_code=1, rs1 data 0x70F0C0E0, rs2 data 0x10003054, sels 0 -> next cycle ALUopcode=1, ALUin_a=0x70F0C0E0, ALUin_b=0x10003054.
- Forward priority: EX rs1=x5, exmem_rd=5 with result 0x11111111, memwb_rd=5 with result 0x22222222 -> ALUin_a=0x11111111. Drop exmem_reg_write -> ALUin_a=0x22222222. Set rs1=x0 -> ALUin_a=0.
- Load-use: EX holds lw x7 (mem_read=1), ID holds add rs2=x7 -> load_use_hazard=1. Apply stall+flush for one cycle -> ex_valid=0, reg_write=0, ALUopcode=0.
- Stall capture: stall=1 with registered rs2=x3, memwb_rd=3 with result 0xDEADBEEF for one cycle. Deassert both -> ALUin_b (b_sel=0) stays 0xDEADBEEF.
- Operand selects: a_sel=1, pc=0x00000100, b_sel=2 -> ALUin_a=0x100, ALUin_b=4. id_alu_code=13 -> ALUopcode=0, ex_illegal=1, ex_reg_write=0.
- Flush priority: stall=1 and flush=1 on the same edge -> bubble inserted, not hold. Build without ID_EX_FWD_EN and repeat the forward-priority scenario -> load_use_hazard=1, and ALUin_a equals the registered data.
